// File: rtl/adpcm_mul_pkg.sv
// Shared types and helpers for the ADPCM multiplier blocks.
// The bound helpers return 64-bit values, so callers resize them.
package adpcm_mul_pkg;

  typedef enum logic {
    MUL_UNSIGNED = 1'b0,
    MUL_SIGNED   = 1'b1
  } mul_mode_t;

  // Width of the exact product after one-bit operand extension.
  function automatic int full_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  function automatic longint umax_bound(input int w);
    return (64'sd1 <<< w) - 64'sd1;
  endfunction

  function automatic longint smin_bound(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic longint smax_bound(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

endpackage

// File: rtl/adpcm_main_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined multiplier.
// The master is the producer/consumer side, the slave is the multiplier.
interface adpcm_main_mul_pipe_if #(
  parameter int W0 = 15,
  parameter int W1 = 13,
  parameter int DW = 12
) ();
  import adpcm_mul_pkg::*;

  logic          in_valid;
  logic          in_ready;
  mul_mode_t     mode;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic          ovf;

  modport master (
    output in_valid, mode, din0, din1, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, mode, din0, din1, out_ready,
    output in_ready, out_valid, dout, ovf
  );

endinterface

// File: rtl/adpcm_mul_scale.sv
// Round, shift and saturate an exact product into the output range.
// Purely combinational so the MAC block can reuse it.
module adpcm_mul_scale
  import adpcm_mul_pkg::*;
#(
  parameter int FW    = 30,
  parameter int DW    = 12,
  parameter int SHIFT = 12,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic signed [FW-1:0] i_p,
  input  mul_mode_t            i_mode,
  output logic [DW-1:0]        o_dout,
  output logic                 o_ovf
);

  localparam int CW = (FW + 1 > DW + 2) ? FW + 1 : DW + 2;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [FW:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ((FW+1)'(1) << RS) : '0;

  localparam logic signed [CW-1:0] UMAX = CW'(umax_bound(DW));
  localparam logic signed [CW-1:0] SMIN = CW'(smin_bound(DW));
  localparam logic signed [CW-1:0] SMAX = CW'(smax_bound(DW));

  logic signed [FW:0]   w_sum;
  logic signed [FW:0]   w_r;
  logic signed [CW-1:0] w_rx;
  logic signed [CW-1:0] w_lo;
  logic signed [CW-1:0] w_hi;
  logic                 w_under;
  logic                 w_over;

  assign w_sum = {i_p[FW-1], i_p} + RND;
  assign w_r   = w_sum >>> SHIFT;
  assign w_rx  = CW'(w_r);

  // Range check against the mode's bounds, then clamp or wrap.
  always_comb begin
    w_lo    = '0;
    w_hi    = UMAX;
    o_dout  = w_rx[DW-1:0];
    if (i_mode == MUL_SIGNED) begin
      w_lo = SMIN;
      w_hi = SMAX;
    end
    w_under = (w_rx < w_lo);
    w_over  = (w_rx > w_hi);
    o_ovf   = w_under | w_over;
    if (SAT != 0) begin
      unique case (1'b1)
        w_under: o_dout = w_lo[DW-1:0];
        w_over:  o_dout = w_hi[DW-1:0];
        default: o_dout = w_rx[DW-1:0];
      endcase
    end
  end

endmodule

// File: rtl/adpcm_main_mul_pipe.sv
// Pipelined signed/unsigned multiplier with scaling and global stall.
// Valid chain, stall logic and stage registers live here.
module adpcm_main_mul_pipe
  import adpcm_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 13,
  parameter int dout_WIDTH = 12,
  parameter int SHIFT      = 12,
  parameter int ROUND      = 1,
  parameter int SAT        = 1
) (
  input logic                  ap_clk,
  input logic                  ap_rst_n,
  adpcm_main_mul_pipe_if.slave bus
);

  localparam int N  = NUM_STAGE;
  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int DW = dout_WIDTH;
  localparam int FW = full_width(W0, W1);

  if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_stage
    $error("NUM_STAGE must be within 1..4");
  end
  if (SHIFT < 0 || SHIFT > W0 + W1) begin : g_bad_shift
    $error("SHIFT must be within 0..din0_WIDTH+din1_WIDTH");
  end
  if (DW < 1 || DW > 62) begin : g_bad_dw
    $error("dout_WIDTH must be within 1..62");
  end
  if (ROUND < 0 || ROUND > 1 || SAT < 0 || SAT > 1) begin : g_bad_flag
    $error("ROUND and SAT must be 0 or 1");
  end
  if (ID < 0) begin : g_bad_id
    $error("ID must be non-negative");
  end

  logic [N-1:0]         r_v;
  logic                 w_adv;
  logic [W0-1:0]        w_a;
  logic [W1-1:0]        w_b;
  mul_mode_t            w_pmode;
  logic signed [FW-1:0] w_ax;
  logic signed [FW-1:0] w_bx;
  logic signed [FW-1:0] w_p;
  logic signed [FW-1:0] w_sp;
  mul_mode_t            w_smode;
  logic                 w_sv;
  logic [DW-1:0]        w_dout;
  logic                 w_ovf;
  logic [DW-1:0]        r_dout;
  logic                 r_ovf;

  assign w_adv         = !r_v[N-1] || bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_v[N-1];
  assign bus.dout      = r_dout;
  assign bus.ovf       = r_ovf;

  // Valid chain: shifts as a unit whenever the pipe advances.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_v <= '0;
    end else if (w_adv) begin
      r_v[0] <= bus.in_valid;
      for (int i = 1; i < N; i++) begin
        r_v[i] <= r_v[i-1];
      end
    end
  end

  if (N >= 2) begin : g_op
    logic [W0-1:0] r_a;
    logic [W1-1:0] r_b;
    mul_mode_t     r_mode;

    // Operand stage: capture operands and mode on acceptance.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        r_a    <= '0;
        r_b    <= '0;
        r_mode <= MUL_UNSIGNED;
      end else if (w_adv && bus.in_valid) begin
        r_a    <= bus.din0;
        r_b    <= bus.din1;
        r_mode <= bus.mode;
      end
    end

    assign w_a     = r_a;
    assign w_b     = r_b;
    assign w_pmode = r_mode;
  end else begin : g_op_comb
    assign w_a     = bus.din0;
    assign w_b     = bus.din1;
    assign w_pmode = bus.mode;
  end

  assign w_ax = FW'($signed({(w_pmode == MUL_SIGNED) && w_a[W0-1], w_a}));
  assign w_bx = FW'($signed({(w_pmode == MUL_SIGNED) && w_b[W1-1], w_b}));
  assign w_p  = w_ax * w_bx;

  if (N >= 3) begin : g_pp
    logic signed [FW-1:0] r_p  [N-2];
    mul_mode_t            r_pm [N-2];

    // Product stages: carry product and mode toward the scaler.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < N - 2; i++) begin
          r_p[i]  <= '0;
          r_pm[i] <= MUL_UNSIGNED;
        end
      end else if (w_adv) begin
        r_p[0]  <= w_p;
        r_pm[0] <= w_pmode;
        for (int i = 1; i < N - 2; i++) begin
          r_p[i]  <= r_p[i-1];
          r_pm[i] <= r_pm[i-1];
        end
      end
    end

    assign w_sp    = r_p[N-3];
    assign w_smode = r_pm[N-3];
    assign w_sv    = r_v[N-2];
  end else if (N == 2) begin : g_pp_two
    assign w_sp    = w_p;
    assign w_smode = w_pmode;
    assign w_sv    = r_v[0];
  end else begin : g_pp_one
    assign w_sp    = w_p;
    assign w_smode = w_pmode;
    assign w_sv    = bus.in_valid;
  end

  adpcm_mul_scale #(
    .FW    (FW),
    .DW    (DW),
    .SHIFT (SHIFT),
    .ROUND (ROUND),
    .SAT   (SAT)
  ) u_scale (
    .i_p    (w_sp),
    .i_mode (w_smode),
    .o_dout (w_dout),
    .o_ovf  (w_ovf)
  );

  // Output stage: load a scaled result only when one moves in.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_dout <= '0;
      r_ovf  <= 1'b0;
    end else if (w_adv && w_sv) begin
      r_dout <= w_dout;
      r_ovf  <= w_ovf;
    end
  end

endmodule

// File: tb/tb_adpcm_main_mul_pipe.sv
// Bench for adpcm_main_mul_pipe: directed vectors, backpressure,
// reset, and a NUM_STAGE 1..4 random sweep against a longint model.
module tb_adpcm_main_mul_pipe;
  import adpcm_mul_pkg::*;

  localparam int W0 = 15;
  localparam int W1 = 13;
  localparam int DW = 12;
  localparam int SH = 12;
  localparam int NV = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   go = 1'b0;

  always #5 clk = ~clk;

  typedef struct {
    bit            m;
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    logic [DW-1:0] ds;
    logic [DW-1:0] dw;
    bit            o;
  } vec_t;

  vec_t vt [NV];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer product, round-half-up, floor shift.
  function automatic void ref_mul(input bit m,
                                  input logic [W0-1:0] a,
                                  input logic [W1-1:0] b,
                                  input bit sat,
                                  output logic [DW-1:0] d,
                                  output logic o);
    longint av, bv, p, r, lo, hi;
    av = m ? longint'($signed(a)) : longint'(a);
    bv = m ? longint'($signed(b)) : longint'(b);
    p  = av * bv + (64'sd1 <<< (SH - 1));
    r  = p >>> SH;
    lo = m ? -(64'sd1 <<< (DW - 1)) : 64'sd0;
    hi = m ? (64'sd1 <<< (DW - 1)) - 1 : (64'sd1 <<< DW) - 1;
    o  = (r < lo) || (r > hi);
    if (sat && r < lo)      d = lo[DW-1:0];
    else if (sat && r > hi) d = hi[DW-1:0];
    else                    d = r[DW-1:0];
  endfunction

  function automatic logic [W0-1:0] pick_a();
    logic [W0-1:0] v;
    v = W0'($urandom);
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = {1'b1, {(W0-1){1'b0}}};
      2: v = '1;
      3: v = {1'b0, {(W0-1){1'b1}}};
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [W1-1:0] pick_b();
    logic [W1-1:0] v;
    v = W1'($urandom);
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = {1'b1, {(W1-1){1'b0}}};
      2: v = '1;
      3: v = {1'b0, {(W1-1){1'b1}}};
      default: ;
    endcase
    return v;
  endfunction

  adpcm_main_mul_pipe_if #(.W0(W0), .W1(W1), .DW(DW)) dv ();
  adpcm_main_mul_pipe_if #(.W0(W0), .W1(W1), .DW(DW)) wv ();

  adpcm_main_mul_pipe #(.NUM_STAGE(3), .SAT(1)) u_d (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (dv.slave)
  );

  adpcm_main_mul_pipe #(.NUM_STAGE(3), .SAT(0)) u_w (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (wv.slave)
  );

  assign wv.in_valid  = dv.in_valid;
  assign wv.mode      = dv.mode;
  assign wv.din0      = dv.din0;
  assign wv.din1      = dv.din1;
  assign wv.out_ready = dv.out_ready;

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int NS = g + 1;
    bit fin = 1'b0;

    adpcm_main_mul_pipe_if #(.W0(W0), .W1(W1), .DW(DW)) sv ();

    adpcm_main_mul_pipe #(.NUM_STAGE(NS)) u_s (
      .ap_clk   (clk),
      .ap_rst_n (rst_n),
      .bus      (sv.slave)
    );

    initial begin
      logic [DW:0]   q [$];
      logic [DW:0]   e;
      logic [DW-1:0] d;
      logic          o;
      bit            pend;
      int            lat;
      string         nm;
      pend = 1'b0;
      sv.in_valid  = 1'b0;
      sv.mode      = MUL_UNSIGNED;
      sv.din0      = '0;
      sv.din1      = '0;
      sv.out_ready = 1'b1;
      wait (go);
      nm = $sformatf("sweep_n%0d", NS);
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        sv.out_ready = ($urandom_range(0, 3) != 0);
        if (!pend) begin
          sv.in_valid = ($urandom_range(0, 3) != 0);
          sv.mode     = mul_mode_t'($urandom_range(0, 1));
          sv.din0     = pick_a();
          sv.din1     = pick_b();
        end
        #1;
        if (sv.out_valid && sv.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_extra: got result %0h expected none",
                     nm, {sv.ovf, sv.dout});
          end else begin
            e = q.pop_front();
            chk({nm, "_res"}, {sv.ovf, sv.dout}, e);
          end
        end
        if (sv.in_valid && sv.in_ready) begin
          ref_mul(sv.mode, sv.din0, sv.din1, 1'b1, d, o);
          q.push_back({o, d});
        end
        pend = sv.in_valid && !sv.in_ready;
      end
      @(negedge clk);
      sv.in_valid  = 1'b0;
      sv.out_ready = 1'b1;
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
        #1;
        if (sv.out_valid) begin
          e = q.pop_front();
          chk({nm, "_drain"}, {sv.ovf, sv.dout}, e);
        end
        @(negedge clk);
      end
      chk({nm, "_left"}, q.size(), 0);
      sv.in_valid = 1'b1;
      sv.mode     = MUL_SIGNED;
      sv.din0     = pick_a();
      sv.din1     = pick_b();
      ref_mul(sv.mode, sv.din0, sv.din1, 1'b1, d, o);
      @(negedge clk);
      sv.in_valid = 1'b0;
      lat = 1;
      while (!sv.out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk({nm, "_lat"}, lat, NS);
      chk({nm, "_lat_res"}, {sv.ovf, sv.dout}, {o, d});
      @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    logic [DW:0]   q [$];
    logic [DW:0]   e;
    logic [W0-1:0] pa [8];
    logic [W1-1:0] pb [8];
    bit            pm [8];
    logic [DW-1:0] d;
    logic [DW-1:0] hold;
    logic          o;
    bit            holding;
    bit            seen;
    bit            stale;
    int            lat, idx, got, stall, cyc, n;

    vt[0] = '{1'b0, 15'd1000,  13'd2000,  12'd488,  12'd488,  1'b0};
    vt[1] = '{1'b1, 15'h7C18,  13'd2000,  12'hE18,  12'hE18,  1'b0};
    vt[2] = '{1'b0, 15'h7FFF,  13'h1FFF,  12'hFFF,  12'hFF6,  1'b1};
    vt[3] = '{1'b1, 15'h4000,  13'h1000,  12'h7FF,  12'h000,  1'b1};
    vt[4] = '{1'b0, 15'd0,     13'd0,     12'h000,  12'h000,  1'b0};
    vt[5] = '{1'b1, 15'h7FFF,  13'h0800,  12'h000,  12'h000,  1'b0};
    vt[6] = '{1'b1, 15'h4000,  13'h0FFF,  12'h800,  12'h004,  1'b1};
    vt[7] = '{1'b1, 15'd4094,  13'h0800,  12'h7FF,  12'h7FF,  1'b0};
    vt[8] = '{1'b1, 15'd4095,  13'h0800,  12'h7FF,  12'h800,  1'b1};
    vt[9] = '{1'b0, 15'd1,     13'h0800,  12'h001,  12'h001,  1'b0};

    dv.in_valid  = 1'b0;
    dv.mode      = MUL_UNSIGNED;
    dv.din0      = '0;
    dv.din1      = '0;
    dv.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", dv.out_valid, 0);
    chk("rst_dout", dv.dout, 0);
    chk("rst_ovf", dv.ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", dv.in_ready, 1);

    for (int i = 0; i < NV; i++) begin
      dv.in_valid = 1'b1;
      dv.mode     = mul_mode_t'(vt[i].m);
      dv.din0     = vt[i].a;
      dv.din1     = vt[i].b;
      @(negedge clk);
      dv.in_valid = 1'b0;
      lat = 1;
      while (!dv.out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("vec%0d_lat", i), lat, 3);
      chk($sformatf("vec%0d_sat_dout", i), dv.dout, vt[i].ds);
      chk($sformatf("vec%0d_sat_ovf", i), dv.ovf, vt[i].o);
      chk($sformatf("vec%0d_wrap_dout", i), wv.dout, vt[i].dw);
      chk($sformatf("vec%0d_wrap_ovf", i), wv.ovf, vt[i].o);
      @(negedge clk);
    end

    for (int i = 0; i < 8; i++) begin
      pa[i] = pick_a();
      pb[i] = pick_b();
      pm[i] = bit'($urandom_range(0, 1));
    end
    idx = 0;
    got = 0;
    stall = 0;
    cyc = 0;
    seen = 1'b0;
    holding = 1'b0;
    hold = '0;
    while (got < 8 && cyc < 60) begin
      cyc++;
      if (dv.out_valid && !seen) begin
        seen  = 1'b1;
        stall = 5;
      end
      dv.out_ready = (stall == 0);
      if (stall > 0) stall--;
      dv.in_valid = (idx < 8);
      if (idx < 8) begin
        dv.mode = mul_mode_t'(pm[idx]);
        dv.din0 = pa[idx];
        dv.din1 = pb[idx];
      end
      #1;
      if (dv.out_valid && !dv.out_ready) begin
        chk("bp_in_ready", dv.in_ready, 0);
        if (holding) chk("bp_hold", dv.dout, hold);
        hold    = dv.dout;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (dv.out_valid && dv.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bp_extra: got result %0h expected none",
                   {dv.ovf, dv.dout});
        end else begin
          e = q.pop_front();
          chk($sformatf("bp_res%0d", got), {dv.ovf, dv.dout}, e);
        end
        got++;
      end
      if (dv.in_valid && dv.in_ready) begin
        ref_mul(pm[idx], pa[idx], pb[idx], 1'b1, d, o);
        q.push_back({o, d});
        idx++;
      end
      @(negedge clk);
    end
    chk("bp_count", got, 8);
    dv.in_valid  = 1'b0;
    dv.out_ready = 1'b1;
    repeat (4) @(negedge clk);

    dv.out_ready = 1'b0;
    dv.in_valid  = 1'b1;
    dv.mode      = MUL_UNSIGNED;
    dv.din0      = 15'd1000;
    dv.din1      = 13'd2000;
    @(negedge clk);
    dv.din0 = 15'd3000;
    @(negedge clk);
    dv.in_valid = 1'b0;
    n = 0;
    while (!dv.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_pre_valid", dv.out_valid, 1);
    chk("rst_pre_dout", dv.dout, 12'd488);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", dv.out_valid, 0);
    chk("rstmid_dout", dv.dout, 0);
    chk("rstmid_ovf", dv.ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dv.out_ready = 1'b1;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dv.out_valid) stale = 1'b1;
    end
    chk("rst_no_stale", stale, 0);
    chk("rst_release_in_ready", dv.in_ready, 1);

    go = 1'b1;
    n = 0;
    while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin)
           && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_done",
        {g_sw[3].fin, g_sw[2].fin, g_sw[1].fin, g_sw[0].fin}, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
